// File: rtl/mont_mult_rr_arbiter_pkg.sv
// Shared definitions for the Montgomery multiplier round-robin arbiter.
// Holds the FSM state encodings and the CLOG2 helper macro used to size
// the owner index.
// No ports (package).

`ifndef CLOG2
`define CLOG2(x) $clog2(x)
`endif

package mont_mult_rr_arbiter_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_START = 2'd1,
      ST_RUN   = 2'd2,
      ST_HOLD  = 2'd3
   } arb_state_e;

endpackage

// File: rtl/mont_mult_rr_arbiter_rr_pick.sv
// Combinational round-robin pick: finds the first set request bit at or
// after ptr, wrapping modulo NUM_REQ.
// Ports:
//   req      in  NUM_REQ      request vector
//   ptr      in  NUM_REQ_LOG  highest-priority index
//   pick     out NUM_REQ      one-hot selected requester (0 when req==0)
//   pick_idx out NUM_REQ_LOG  binary index of the selected requester

module mont_mult_rr_arbiter_rr_pick #(
   parameter int NUM_REQ     = 4,
   parameter int NUM_REQ_LOG = 2
) (
   input  logic [NUM_REQ-1:0]     req,
   input  logic [NUM_REQ_LOG-1:0] ptr,
   output logic [NUM_REQ-1:0]     pick,
   output logic [NUM_REQ_LOG-1:0] pick_idx
);

   logic [NUM_REQ-1:0]   rot;
   logic [NUM_REQ_LOG:0] off;
   logic [NUM_REQ_LOG:0] sum;

   always_comb begin
      // Rotating the doubled vector right by ptr puts requester ptr at bit 0,
      // so a plain lowest-bit priority encode gives the distance from ptr.
      rot = NUM_REQ'({req, req} >> ptr);
      off = '0;
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         if (rot[i]) off = (NUM_REQ_LOG + 1)'(i);
      end
      sum = {1'b0, ptr} + off;
      if (sum >= (NUM_REQ_LOG + 1)'(NUM_REQ)) sum = sum - (NUM_REQ_LOG + 1)'(NUM_REQ);
      pick_idx = sum[NUM_REQ_LOG-1:0];
      pick = '0;
      if (|req) pick[pick_idx] = 1'b1;
   end

endmodule

// File: rtl/mont_mult_rr_arbiter.sv
// Round-robin arbiter/sequencer sharing one two-lane Montgomery multiplier
// between NUM_REQ requesters. Grants exclusive ownership, issues a 1-cycle
// start, waits for done, then holds the result memories for the owner until
// it releases them. All outputs are registered.
// Optional feature macro: MONT_ARB_PERF_CNT_EN (adds op_cnt / busy_cnt).
// Ports:
//   clk        in   1                    clock
//   rst        in   1                    synchronous reset, active-high
//   req        in   NUM_REQ              level request per requester
//   release_i  in   NUM_REQ              owner finished reading results (pulse)
//   grant      out  NUM_REQ              one-hot ownership, START..HOLD
//   owner      out  NUM_REQ_LOG          binary owner index (mux select)
//   busy       out  1                    any state other than IDLE
//   mult_start out  1                    1-cycle multiplier start
//   mult_done  in   1                    1-cycle multiplier done
//   req_done   out  NUM_REQ              1-cycle results-readable pulse to owner
//   proto_err  out  1                    sticky, set by unexpected mult_done
//   op_cnt     out  NUM_REQ*CNT_WIDTH    completed ops per requester (perf build)
//   busy_cnt   out  CNT_WIDTH            busy cycles (perf build)
//
// state   | meaning
// IDLE    | no owner; arbitrate on any req
// START   | owner granted, mult_start high this cycle
// RUN     | multiplier running, waiting for mult_done
// HOLD    | results readable by owner until release_i[owner]

module mont_mult_rr_arbiter
   import mont_mult_rr_arbiter_pkg::*;
#(
   parameter int NUM_REQ     = 4,
   parameter int NUM_REQ_LOG = `CLOG2(NUM_REQ),
   parameter int CNT_WIDTH   = 32
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [NUM_REQ-1:0]     req,
   input  logic [NUM_REQ-1:0]     release_i,
   output logic [NUM_REQ-1:0]     grant,
   output logic [NUM_REQ_LOG-1:0] owner,
   output logic                   busy,
   output logic                   mult_start,
   input  logic                   mult_done,
   output logic [NUM_REQ-1:0]     req_done,
   output logic                   proto_err
`ifdef MONT_ARB_PERF_CNT_EN
   ,
   output logic [NUM_REQ*CNT_WIDTH-1:0] op_cnt,
   output logic [CNT_WIDTH-1:0]         busy_cnt
`endif
);

   arb_state_e state_q, state_d;

   logic [NUM_REQ_LOG-1:0] ptr_q, ptr_d;
   logic [NUM_REQ-1:0]     grant_d;
   logic [NUM_REQ_LOG-1:0] owner_d;
   logic                   busy_d;
   logic                   mult_start_d;
   logic [NUM_REQ-1:0]     req_done_d;
   logic                   proto_err_d;

   logic [NUM_REQ-1:0]     pick;
   logic [NUM_REQ_LOG-1:0] pick_idx;

   mont_mult_rr_arbiter_rr_pick #(
      .NUM_REQ     (NUM_REQ),
      .NUM_REQ_LOG (NUM_REQ_LOG)
   ) u_rr_pick (
      .req      (req),
      .ptr      (ptr_q),
      .pick     (pick),
      .pick_idx (pick_idx)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         ptr_q      <= '0;
         grant      <= '0;
         owner      <= '0;
         busy       <= 1'b0;
         mult_start <= 1'b0;
         req_done   <= '0;
         proto_err  <= 1'b0;
      end else begin
         state_q    <= state_d;
         ptr_q      <= ptr_d;
         grant      <= grant_d;
         owner      <= owner_d;
         busy       <= busy_d;
         mult_start <= mult_start_d;
         req_done   <= req_done_d;
         proto_err  <= proto_err_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:  if (|req) state_d = ST_START;
         ST_START: state_d = ST_RUN;
         ST_RUN:   if (mult_done) state_d = ST_HOLD;
         ST_HOLD:  if (release_i[owner]) state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   // Next values of the registered outputs; a release arriving with
   // mult_done is dropped because the FSM is still in RUN.
   always_comb begin
      grant_d      = grant;
      owner_d      = owner;
      busy_d       = busy;
      ptr_d        = ptr_q;
      mult_start_d = 1'b0;
      req_done_d   = '0;
      proto_err_d  = proto_err | (mult_done && (state_q != ST_RUN));
      case (state_q)
         ST_IDLE: begin
            if (|req) begin
               grant_d      = pick;
               owner_d      = pick_idx;
               busy_d       = 1'b1;
               mult_start_d = 1'b1;
            end
         end
         ST_RUN: begin
            if (mult_done) req_done_d = grant;
         end
         ST_HOLD: begin
            if (release_i[owner]) begin
               grant_d = '0;
               busy_d  = 1'b0;
               ptr_d   = (owner == NUM_REQ_LOG'(NUM_REQ - 1)) ? '0 : owner + 1'b1;
            end
         end
         default: ;
      endcase
   end

`ifdef MONT_ARB_PERF_CNT_EN
   logic [CNT_WIDTH-1:0] op_cnt_q [NUM_REQ];

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NUM_REQ; i++) op_cnt_q[i] <= '0;
         busy_cnt <= '0;
      end else begin
         for (int i = 0; i < NUM_REQ; i++) begin
            if (req_done[i] && (op_cnt_q[i] != '1)) op_cnt_q[i] <= op_cnt_q[i] + 1'b1;
         end
         if (busy && (busy_cnt != '1)) busy_cnt <= busy_cnt + 1'b1;
      end
   end

   for (genvar g = 0; g < NUM_REQ; g++) begin : g_op_cnt
      assign op_cnt[g*CNT_WIDTH +: CNT_WIDTH] = op_cnt_q[g];
   end
`else
   // Counter width only matters when the perf counters are built in.
   localparam int unused_cnt_width = CNT_WIDTH;
`endif

endmodule

// File: tb/tb_mont_mult_rr_arbiter.sv
module tb_mont_mult_rr_arbiter;

   localparam int NUM_REQ   = 4;
   localparam int CNT_WIDTH = 32;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] req;
   logic [3:0] release_i;
   logic [3:0] grant;
   logic [1:0] owner;
   logic       busy;
   logic       mult_start;
   logic       mult_done;
   logic [3:0] req_done;
   logic       proto_err;
`ifdef MONT_ARB_PERF_CNT_EN
   logic [NUM_REQ*CNT_WIDTH-1:0] op_cnt;
   logic [CNT_WIDTH-1:0]         busy_cnt;
`endif

   int n_pass  = 0;
   int n_total = 0;

   mont_mult_rr_arbiter #(
      .NUM_REQ   (NUM_REQ),
      .CNT_WIDTH (CNT_WIDTH)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .req        (req),
      .release_i  (release_i),
      .grant      (grant),
      .owner      (owner),
      .busy       (busy),
      .mult_start (mult_start),
      .mult_done  (mult_done),
      .req_done   (req_done),
      .proto_err  (proto_err)
`ifdef MONT_ARB_PERF_CNT_EN
      ,
      .op_cnt     (op_cnt),
      .busy_cnt   (busy_cnt)
`endif
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_total++;
      assert (obs === exp) begin
         n_pass++;
      end else begin
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One full operation from IDLE with the caller's req already applied.
   task automatic run_op(input logic [3:0] exp_grant, input logic [1:0] exp_owner);
      tick();
      chk("op_grant", grant, exp_grant);
      chk("op_owner", owner, exp_owner);
      chk("op_start", mult_start, 1'b1);
      tick();
      chk("op_start_off", mult_start, 1'b0);
      mult_done = 1'b1;
      tick();
      mult_done = 1'b0;
      chk("op_req_done", req_done, exp_grant);
      release_i = exp_grant;
      tick();
      release_i = '0;
      chk("op_rel_grant", grant, 4'b0000);
      chk("op_rel_busy", busy, 1'b0);
   endtask

   initial begin
      rst = 1'b1; req = '0; release_i = '0; mult_done = 1'b0;
      tick(); tick();
      rst = 1'b0;
      chk("rst_grant", grant, 4'b0000);
      chk("rst_owner", owner, 2'd0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_start", mult_start, 1'b0);
      chk("rst_req_done", req_done, 4'b0000);
      chk("rst_proto_err", proto_err, 1'b0);

      // single op from requester 0, done 20 cycles after start; req dropped after grant
      req = 4'b0001;
      tick();
      chk("t1_grant", grant, 4'b0001);
      chk("t1_start", mult_start, 1'b1);
      chk("t1_busy", busy, 1'b1);
      req = 4'b0000;
      for (int i = 0; i < 19; i++) tick();
      chk("t1_wait_req_done", req_done, 4'b0000);
      chk("t1_wait_grant", grant, 4'b0001);
      mult_done = 1'b1;
      tick();
      mult_done = 1'b0;
      chk("t1_req_done", req_done, 4'b0001);
      tick();
      chk("t1_req_done_pulse", req_done, 4'b0000);
      chk("t1_hold_grant", grant, 4'b0001);
      release_i = 4'b0001;
      tick();
      release_i = '0;
      chk("t1_rel_grant", grant, 4'b0000);
      chk("t1_rel_busy", busy, 1'b0);
      chk("t1_no_regrant", mult_start, 1'b0);

      // all requesters held: grants rotate 0,1,2,3,0
      rst = 1'b1; tick(); rst = 1'b0;
      req = 4'b1111;
      run_op(4'b0001, 2'd0);
      run_op(4'b0010, 2'd1);
      run_op(4'b0100, 2'd2);
      run_op(4'b1000, 2'd3);
      run_op(4'b0001, 2'd0);
      req = '0;
      tick();
      chk("t2_idle_busy", busy, 1'b0);

      // ptr=1 now; req 0 wraps. Release with mult_done and non-owner release ignored.
      req = 4'b0001;
      tick();
      chk("t3_grant", grant, 4'b0001);
      req = '0;
      tick();
      mult_done = 1'b1; release_i = 4'b0001;
      tick();
      mult_done = 1'b0; release_i = '0;
      chk("t3_req_done", req_done, 4'b0001);
      chk("t3_rel_with_done_ignored", grant, 4'b0001);
      release_i = 4'b0100;
      tick();
      release_i = '0;
      chk("t3_nonowner_grant", grant, 4'b0001);
      chk("t3_nonowner_busy", busy, 1'b1);
      tick();
      chk("t3_still_hold", grant, 4'b0001);
      release_i = 4'b0001;
      tick();
      release_i = '0;
      chk("t3_rel_grant", grant, 4'b0000);
      chk("t3_rel_busy", busy, 1'b0);

      // mult_done while IDLE
      mult_done = 1'b1;
      tick();
      mult_done = 1'b0;
      chk("t4_proto_err", proto_err, 1'b1);
      chk("t4_busy", busy, 1'b0);
      chk("t4_start", mult_start, 1'b0);
      tick();
      chk("t4_proto_sticky", proto_err, 1'b1);
      chk("t4_still_idle", grant, 4'b0000);

      // reset in RUN with owner 2
      req = 4'b0100;
      tick();
      chk("t5_owner", owner, 2'd2);
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("t5_rst_grant", grant, 4'b0000);
      chk("t5_rst_owner", owner, 2'd0);
      chk("t5_rst_busy", busy, 1'b0);
      chk("t5_rst_proto", proto_err, 1'b0);
      chk("t5_rst_req_done", req_done, 4'b0000);
      tick();
      chk("t5_regrant", grant, 4'b0100);
      req = '0;
      // mult_done in the START cycle: error, and FSM still goes to RUN only
      mult_done = 1'b1;
      tick();
      mult_done = 1'b0;
      chk("t5_start_done_err", proto_err, 1'b1);
      chk("t5_start_done_no_req_done", req_done, 4'b0000);
      mult_done = 1'b1;
      tick();
      mult_done = 1'b0;
      chk("t5_req_done", req_done, 4'b0100);
      release_i = 4'b0100;
      tick();
      release_i = '0;
      chk("t5_rel", busy, 1'b0);

      // ptr=3: pick 3 over 0, then owner 3 release wraps ptr to 0
      req = 4'b1001;
      run_op(4'b1000, 2'd3);
      run_op(4'b0001, 2'd0);
      req = '0;

`ifdef MONT_ARB_PERF_CNT_EN
      rst = 1'b1; tick(); rst = 1'b0;
      chk("t6_rst_busy_cnt", busy_cnt, 32'd0);
      req = 4'b0010;
      run_op(4'b0010, 2'd1);
      run_op(4'b0010, 2'd1);
      run_op(4'b0010, 2'd1);
      req = '0;
      tick();
      chk("t6_op_cnt0", op_cnt[0*CNT_WIDTH +: CNT_WIDTH], 32'd0);
      chk("t6_op_cnt1", op_cnt[1*CNT_WIDTH +: CNT_WIDTH], 32'd3);
      chk("t6_op_cnt2", op_cnt[2*CNT_WIDTH +: CNT_WIDTH], 32'd0);
      chk("t6_op_cnt3", op_cnt[3*CNT_WIDTH +: CNT_WIDTH], 32'd0);
      chk("t6_busy_cnt", busy_cnt, 32'd9);
`endif

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
